ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Consumer end of the decode→execute bundle (alu_ops/io_ops modports, operands, ma/wb forwarding taps).
- Resolves operand forwarding and computes the ALU result or the load/store address, then registers everything into the EX/MA pipeline register.
- Detects the load-use hazard against its own registered load and requests a one-cycle stall from decode.
- Sits between the decode register and the memory-access stage.

Parameters:
- XLEN, 64, datapath width
- RESET_PC, 64'h0, reset value of ex_pc

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- alu_ops  input  modport alu_ops.dst  one-hot ALU op: add, sub, and, or, xor, sll, srl, sra, slt
- io_ops  input  modport io_ops.dst  load_op, store_op
- in_valid  input  1  decode slot holds an instruction
- stall  input  1  downstream stall; hold EX/MA register
- clear  input  1  flush; insert bubble
- compressed  input  1  instruction is 16-bit
- pc  input  XLEN  instruction PC
- rd, rs1, rs2  input  5 each  register indices
- data1, data2  input  XLEN  register-file read data
- imm  input  XLEN  sign-extended immediate
- with_imm  input  1  operand B = imm
- ma_rd, wb_rd  input  5 each  forwarding destinations
- ma_data, wb_data  input  XLEN  forwarding data
- hazard_stall  output  1  load-use stall request to decode (combinational)
- ex_valid  output  1  EX/MA holds a valid instruction
- ex_pc  output  XLEN  registered PC
- ex_next_pc  output  XLEN  pc+2 or pc+4
- ex_rd  output  5  registered destination
- ex_result  output  XLEN  ALU result
- ex_addr  output  XLEN  load/store address
- ex_store_data  output  XLEN  forwarded rs2 value
- ex_load, ex_store  output  1 each  registered io ops

Behaviour:
- Reset (async, rst=1): ex_valid=0, ex_pc=RESET_PC, ex_next_pc=RESET_PC, ex_rd=0, ex_result=0, ex_addr=0, ex_store_data=0, ex_load=0, ex_store=0. Outputs hold these values while rst is high. Reset mid-operation discards the held instruction.
- Forwarding, per source operand: index 0 → 0; else matches ma_rd → ma_data; else matches wb_rd → wb_data; else dataN. MA has priority over WB.
- Operand A = fwd1. Operand B = with_imm ? imm : fwd2.
- ALU:
  - add/sub use modulo 2^XLEN.
  - and/or/xor are bitwise.
  - sll/srl/sra shift by B[5:0]; sra is arithmetic.
  - slt is a signed compare; result is {63'b0, A<B}.
  - No op set → result 0. Multiple ops set → priority add>sub>and>or>xor>sll>srl>sra>slt.
- ex_addr = fwd1 + imm, regardless of with_imm. ex_store_data = fwd2.
- ex_next_pc = pc + (compressed ? 2 : 4).
- Load-use hazard: hazard_stall = ex_valid & ex_load & (ex_rd≠0) & ((ex_rd==rs1) | (ex_rd==rs2 & ~with_imm)) & in_valid.
- EX/MA register update, 1-cycle latency, priority in this order:
  1. clear: bubble (ex_valid=0, ex_rd=0, ex_load=0, ex_store=0; data fields don't-care, held).
  2. stall: hold all fields.
  3. hazard_stall: bubble; decode replays the instruction next cycle.
  4. Otherwise capture: ex_valid=in_valid, and io ops/rd are gated by in_valid.
- clear and stall together → clear wins.
- hazard_stall together with stall → hold; hazard_stall stays asserted.
- rd=0 with a valid instruction is captured as-is; downstream ignores the write.

Decomposition:
- Shared package ex_pkg:
  - XLEN
  - ALU op index enum for the priority encoder
  - ex_ma_t packed struct for the EX/MA register fields
  - ENABLE/DISABLE macros from isa.vh remain the bit constants
- One sub-module, ex_alu: purely combinational (A, B, op vector → result). The registered stage, forwarding and hazard logic stay in ex_stage.

Test Plan:
- Forward from MA: add, rs1=3, rs2=4, data1=256, data2=512, ma_rd=3, ma_data=0xDDAA, wb_rd=6 → next cycle ex_result=0xDFAA, ex_valid=1.
- Immediate and WB forwarding with io: with_imm=1, imm=1024, rs1=6 (wb_data=0xDCBA), load_op=1, store_op=1 → ex_result=0xE0BA, ex_addr=0xE0BA, ex_load=1, ex_store=1.
- Shifts and slt: A=0x8000_0000_0000_0000, B=4.
  - sra → 0xF800_0000_0000_0000
  - srl → 0x0800_0000_0000_0000
  - slt with B=1 → 1
- Load-use: cycle N loads into rd=5; cycle N+1 add with rs1=5 → hazard_stall=1 and a bubble is registered. Cycle N+2, with the load retired to MA (ma_rd=5), the add captures the forwarded value.
- Stall/clear: hold stall=1 for 3 cycles with changing inputs → outputs frozen. Assert clear with stall=1 → ex_valid=0 next cycle.
- Async reset mid-stream: assert rst between clock edges → outputs reach reset values immediately. PC with compressed=1, pc=0x400 after reset release → ex_next_pc=0x402.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute stage: ALU op indices and the EX/MA register layout.
// Also holds the datapath width and the single-bit enable constants.
package ex_pkg;

   localparam int XLEN  = 64;
   localparam int ALU_N = 9;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   // Bit positions in the ALU op vector; lower index wins when several are set.
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SLL = 4'd5,
      ALU_SRL = 4'd6,
      ALU_SRA = 4'd7,
      ALU_SLT = 4'd8
   } alu_idx_e;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] next_pc;
      logic [4:0]      rd;
      logic [XLEN-1:0] result;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] store_data;
      logic            load;
      logic            store;
   } ex_ma_t;

endpackage

// File: rtl/ex_if.sv
// Decode-to-execute control bundles: one-hot ALU operation and memory io operation.
// The execute stage consumes both through their dst modports.
interface alu_ops_if;
   logic op_add;
   logic op_sub;
   logic op_and;
   logic op_or;
   logic op_xor;
   logic op_sll;
   logic op_srl;
   logic op_sra;
   logic op_slt;

   modport src (output op_add, op_sub, op_and, op_or, op_xor, op_sll, op_srl, op_sra, op_slt);
   modport dst (input  op_add, op_sub, op_and, op_or, op_xor, op_sll, op_srl, op_sra, op_slt);
endinterface

interface io_ops_if;
   logic load_op;
   logic store_op;

   modport src (output load_op, store_op);
   modport dst (input  load_op, store_op);
endinterface

// File: rtl/ex_alu.sv
// Combinational ALU: selects one operation from the op vector with a fixed priority
// (add highest, slt lowest) and produces zero when no op is requested.
module ex_alu
   import ex_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [ALU_N-1:0] op,
   output logic [W-1:0]     result
);

   localparam int SH = $clog2(W);

   logic [SH-1:0] shamt;
   logic          lt;

   assign shamt = b[SH-1:0];
   assign lt    = $signed(a) < $signed(b);

   // Priority-encoded operation select.
   always_comb begin
      result = '0;
      if (op[ALU_ADD]) begin
         result = a + b;
      end else if (op[ALU_SUB]) begin
         result = a - b;
      end else if (op[ALU_AND]) begin
         result = a & b;
      end else if (op[ALU_OR]) begin
         result = a | b;
      end else if (op[ALU_XOR]) begin
         result = a ^ b;
      end else if (op[ALU_SLL]) begin
         result = a << shamt;
      end else if (op[ALU_SRL]) begin
         result = a >> shamt;
      end else if (op[ALU_SRA]) begin
         result = $unsigned($signed(a) >>> shamt);
      end else if (op[ALU_SLT]) begin
         result = {{(W-1){1'b0}}, lt};
      end else begin
         result = '0;
      end
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU / address compute, load-use hazard detection
// and the EX/MA pipeline register.
module ex_stage
   import ex_pkg::*;
#(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
   input  logic            clk,
   input  logic            rst,
   alu_ops_if.dst          alu_ops,
   io_ops_if.dst           io_ops,
   input  logic            in_valid,
   input  logic            stall,
   input  logic            clear,
   input  logic            compressed,
   input  logic [XLEN-1:0] pc,
   input  logic [4:0]      rd,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic [XLEN-1:0] imm,
   input  logic            with_imm,
   input  logic [4:0]      ma_rd,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] ma_data,
   input  logic [XLEN-1:0] wb_data,
   output logic            hazard_stall,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_next_pc,
   output logic [4:0]      ex_rd,
   output logic [XLEN-1:0] ex_result,
   output logic [XLEN-1:0] ex_addr,
   output logic [XLEN-1:0] ex_store_data,
   output logic            ex_load,
   output logic            ex_store
);

   // The more recent producer (MA) wins over WB; x0 always reads as zero.
   function automatic logic [XLEN-1:0] fwd(
      input logic [4:0]      rs,
      input logic [XLEN-1:0] rdata,
      input logic [4:0]      m_rd,
      input logic [XLEN-1:0] m_data,
      input logic [4:0]      w_rd,
      input logic [XLEN-1:0] w_data
   );
      logic [XLEN-1:0] v;
      if (rs == 5'd0) begin
         v = '0;
      end else if (rs == m_rd) begin
         v = m_data;
      end else if (rs == w_rd) begin
         v = w_data;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   logic [XLEN-1:0]  fwd1;
   logic [XLEN-1:0]  fwd2;
   logic [XLEN-1:0]  op_b;
   logic [XLEN-1:0]  alu_result;
   logic [ALU_N-1:0] op_vec;
   ex_ma_t           cur;
   ex_ma_t           nxt;

   assign fwd1 = fwd(rs1, data1, ma_rd, ma_data, wb_rd, wb_data);
   assign fwd2 = fwd(rs2, data2, ma_rd, ma_data, wb_rd, wb_data);
   assign op_b = with_imm ? imm : fwd2;

   // Pack the named op strobes into the indexed vector the ALU encodes.
   always_comb begin
      op_vec          = '0;
      op_vec[ALU_ADD] = alu_ops.op_add;
      op_vec[ALU_SUB] = alu_ops.op_sub;
      op_vec[ALU_AND] = alu_ops.op_and;
      op_vec[ALU_OR]  = alu_ops.op_or;
      op_vec[ALU_XOR] = alu_ops.op_xor;
      op_vec[ALU_SLL] = alu_ops.op_sll;
      op_vec[ALU_SRL] = alu_ops.op_srl;
      op_vec[ALU_SRA] = alu_ops.op_sra;
      op_vec[ALU_SLT] = alu_ops.op_slt;
   end

   ex_alu #(.W(XLEN)) u_alu (
      .a      (fwd1),
      .b      (op_b),
      .op     (op_vec),
      .result (alu_result)
   );

   // An rs2 that only feeds the immediate path is not actually consumed.
   assign hazard_stall = cur.valid & cur.load & (cur.rd != 5'd0) & in_valid &
                         ((cur.rd == rs1) | ((cur.rd == rs2) & ~with_imm));

   // Next EX/MA contents: clear, then stall-hold, then hazard bubble, then capture.
   always_comb begin
      nxt = cur;
      if (clear) begin
         nxt.valid = DISABLE;
         nxt.rd    = 5'd0;
         nxt.load  = DISABLE;
         nxt.store = DISABLE;
      end else if (stall) begin
         nxt = cur;
      end else if (hazard_stall) begin
         nxt.valid = DISABLE;
         nxt.rd    = 5'd0;
         nxt.load  = DISABLE;
         nxt.store = DISABLE;
      end else begin
         nxt.valid      = in_valid;
         nxt.pc         = pc;
         nxt.next_pc    = pc + (compressed ? XLEN'(2) : XLEN'(4));
         nxt.rd         = in_valid ? rd : 5'd0;
         nxt.result     = alu_result;
         nxt.addr       = fwd1 + imm;
         nxt.store_data = fwd2;
         nxt.load       = in_valid & io_ops.load_op;
         nxt.store      = in_valid & io_ops.store_op;
      end
   end

   // EX/MA pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur.valid      <= DISABLE;
         cur.pc         <= RESET_PC;
         cur.next_pc    <= RESET_PC;
         cur.rd         <= 5'd0;
         cur.result     <= '0;
         cur.addr       <= '0;
         cur.store_data <= '0;
         cur.load       <= DISABLE;
         cur.store      <= DISABLE;
      end else begin
         cur <= nxt;
      end
   end

   assign ex_valid      = cur.valid;
   assign ex_pc         = cur.pc;
   assign ex_next_pc    = cur.next_pc;
   assign ex_rd         = cur.rd;
   assign ex_result     = cur.result;
   assign ex_addr       = cur.addr;
   assign ex_store_data = cur.store_data;
   assign ex_load       = cur.load;
   assign ex_store      = cur.store;

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, stall, clear, compressed, with_imm;
   logic [63:0] pc, data1, data2, imm, ma_data, wb_data;
   logic [4:0]  rd, rs1, rs2, ma_rd, wb_rd;
   logic        hazard_stall, ex_valid, ex_load, ex_store;
   logic [63:0] ex_pc, ex_next_pc, ex_result, ex_addr, ex_store_data;
   logic [4:0]  ex_rd;

   int n_cmp = 0;
   int n_mis = 0;

   localparam logic [8:0] OP_NONE = 9'h000, OP_ADD = 9'h001, OP_SUB = 9'h002, OP_AND = 9'h004,
                          OP_OR = 9'h008, OP_XOR = 9'h010, OP_SLL = 9'h020, OP_SRL = 9'h040,
                          OP_SRA = 9'h080, OP_SLT = 9'h100;

   alu_ops_if alu_if ();
   io_ops_if  io_if ();

   always #5 clk = ~clk;

   ex_stage #(.XLEN(64), .RESET_PC(64'h0)) dut (
      .clk(clk), .rst(rst), .alu_ops(alu_if), .io_ops(io_if),
      .in_valid(in_valid), .stall(stall), .clear(clear), .compressed(compressed),
      .pc(pc), .rd(rd), .rs1(rs1), .rs2(rs2), .data1(data1), .data2(data2),
      .imm(imm), .with_imm(with_imm), .ma_rd(ma_rd), .wb_rd(wb_rd),
      .ma_data(ma_data), .wb_data(wb_data), .hazard_stall(hazard_stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_next_pc(ex_next_pc), .ex_rd(ex_rd),
      .ex_result(ex_result), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
      .ex_load(ex_load), .ex_store(ex_store)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [8:0] v);
      {alu_if.op_slt, alu_if.op_sra, alu_if.op_srl, alu_if.op_sll, alu_if.op_xor,
       alu_if.op_or, alu_if.op_and, alu_if.op_sub, alu_if.op_add} = v;
   endtask

   task automatic idle();
      in_valid = 1'b0; stall = 1'b0; clear = 1'b0; compressed = 1'b0; with_imm = 1'b0;
      pc = 64'h0; data1 = 64'h0; data2 = 64'h0; imm = 64'h0; ma_data = 64'h0; wb_data = 64'h0;
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; ma_rd = 5'd0; wb_rd = 5'd0;
      set_op(OP_NONE);
      io_if.load_op = 1'b0; io_if.store_op = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One ALU vector: A from rs1 (no forwarding), B from the immediate.
   task automatic alu_vec(input string tag, input logic [8:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp);
      idle();
      in_valid = 1'b1; set_op(op); rs1 = 5'd1; data1 = a; with_imm = 1'b1; imm = b; rd = 5'd2;
      tick();
      chk(tag, ex_result, exp);
   endtask

   initial begin
      idle();
      tick();
      tick();
      chk("rst_valid", {63'd0, ex_valid}, 64'd0);
      chk("rst_pc", ex_pc, 64'h0);
      chk("rst_next_pc", ex_next_pc, 64'h0);
      chk("rst_result", ex_result, 64'h0);
      chk("rst_addr", ex_addr, 64'h0);
      chk("rst_load", {63'd0, ex_load}, 64'd0);
      rst = 1'b0;

      // forward from MA
      idle();
      in_valid = 1'b1; set_op(OP_ADD); pc = 64'h100; rd = 5'd10;
      rs1 = 5'd3; rs2 = 5'd4; data1 = 64'd256; data2 = 64'd512;
      ma_rd = 5'd3; ma_data = 64'hDDAA; wb_rd = 5'd6; wb_data = 64'hDCBA;
      tick();
      chk("fwd_ma_result", ex_result, 64'hDFAA);
      chk("fwd_ma_valid", {63'd0, ex_valid}, 64'd1);
      chk("fwd_ma_store_data", ex_store_data, 64'h200);
      chk("fwd_ma_pc", ex_pc, 64'h100);
      chk("fwd_ma_next_pc", ex_next_pc, 64'h104);
      chk("fwd_ma_rd", {59'd0, ex_rd}, 64'd10);

      // immediate + WB forwarding with io ops
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rd = 5'd7; with_imm = 1'b1; imm = 64'd1024;
      rs1 = 5'd6; data1 = 64'h1; ma_rd = 5'd3; ma_data = 64'hDDAA; wb_rd = 5'd6; wb_data = 64'hDCBA;
      io_if.load_op = 1'b1; io_if.store_op = 1'b1;
      tick();
      chk("imm_wb_result", ex_result, 64'hE0BA);
      chk("imm_wb_addr", ex_addr, 64'hE0BA);
      chk("imm_wb_load", {63'd0, ex_load}, 64'd1);
      chk("imm_wb_store", {63'd0, ex_store}, 64'd1);

      // invalid slot gates io ops and rd
      idle();
      io_if.load_op = 1'b1; io_if.store_op = 1'b1; rd = 5'd9;
      tick();
      chk("inv_valid", {63'd0, ex_valid}, 64'd0);
      chk("inv_load", {63'd0, ex_load}, 64'd0);
      chk("inv_store", {63'd0, ex_store}, 64'd0);
      chk("inv_rd", {59'd0, ex_rd}, 64'd0);

      // MA over WB priority, x0 reads zero
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rs1 = 5'd3; with_imm = 1'b1; imm = 64'h1;
      ma_rd = 5'd3; ma_data = 64'h11; wb_rd = 5'd3; wb_data = 64'h22;
      tick();
      chk("prio_ma_wb", ex_result, 64'h12);
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rs1 = 5'd0; data1 = 64'h99; with_imm = 1'b1; imm = 64'h1;
      ma_rd = 5'd0; ma_data = 64'h55;
      tick();
      chk("x0_zero", ex_result, 64'h1);

      // address uses imm even when B comes from rs2
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rs1 = 5'd1; data1 = 64'h1000; rs2 = 5'd2; data2 = 64'h5;
      imm = 64'h20; with_imm = 1'b0;
      tick();
      chk("addr_res", ex_result, 64'h1005);
      chk("addr_addr", ex_addr, 64'h1020);
      chk("addr_sdata", ex_store_data, 64'h5);

      alu_vec("sra", OP_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
      alu_vec("srl", OP_SRL, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
      alu_vec("sll", OP_SLL, 64'h1, 64'd4, 64'h10);
      alu_vec("srl_shamt6", OP_SRL, 64'h100, 64'h44, 64'h10);
      alu_vec("slt_neg", OP_SLT, 64'h8000_0000_0000_0000, 64'd1, 64'd1);
      alu_vec("slt_signed", OP_SLT, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      alu_vec("sub", OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
      alu_vec("and", OP_AND, 64'hF0F0, 64'hFF00, 64'hF000);
      alu_vec("or", OP_OR, 64'hF0F0, 64'hFF00, 64'hFFF0);
      alu_vec("xor", OP_XOR, 64'hF0F0, 64'hFF00, 64'h0FF0);
      alu_vec("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
      alu_vec("multi_add_sub", OP_ADD | OP_SUB, 64'd5, 64'd7, 64'd12);
      alu_vec("multi_or_slt", OP_OR | OP_SLT, 64'hF0, 64'h0F, 64'hFF);
      alu_vec("no_op", OP_NONE, 64'd5, 64'd7, 64'd0);

      // load-use hazard
      idle();
      in_valid = 1'b1; set_op(OP_ADD); io_if.load_op = 1'b1; rd = 5'd5;
      rs1 = 5'd1; data1 = 64'h100; with_imm = 1'b1; imm = 64'h8;
      tick();
      chk("ld_load", {63'd0, ex_load}, 64'd1);
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rd = 5'd8; rs1 = 5'd1; rs2 = 5'd5; with_imm = 1'b1;
      #1;
      chk("hz_rs2_imm", {63'd0, hazard_stall}, 64'd0);
      with_imm = 1'b0;
      #1;
      chk("hz_rs2", {63'd0, hazard_stall}, 64'd1);
      rs1 = 5'd5; rs2 = 5'd2; data1 = 64'hDEAD; data2 = 64'h10;
      #1;
      chk("hz_rs1", {63'd0, hazard_stall}, 64'd1);
      tick();
      chk("hz_bubble_valid", {63'd0, ex_valid}, 64'd0);
      chk("hz_bubble_load", {63'd0, ex_load}, 64'd0);
      chk("hz_released", {63'd0, hazard_stall}, 64'd0);
      ma_rd = 5'd5; ma_data = 64'h77;
      tick();
      chk("hz_replay_result", ex_result, 64'h87);
      chk("hz_replay_valid", {63'd0, ex_valid}, 64'd1);
      chk("hz_replay_rd", {59'd0, ex_rd}, 64'd8);

      // hazard together with stall holds and keeps requesting
      idle();
      in_valid = 1'b1; set_op(OP_ADD); io_if.load_op = 1'b1; rd = 5'd5; rs1 = 5'd1;
      tick();
      idle();
      in_valid = 1'b1; set_op(OP_ADD); rs1 = 5'd5; rd = 5'd8; stall = 1'b1;
      tick();
      chk("hz_stall_hazard", {63'd0, hazard_stall}, 64'd1);
      chk("hz_stall_load", {63'd0, ex_load}, 64'd1);
      stall = 1'b0;
      tick();
      chk("hz_stall_bubble", {63'd0, ex_valid}, 64'd0);

      // stall freezes outputs, clear beats stall
      idle();
      in_valid = 1'b1; set_op(OP_ADD); pc = 64'h200; rd = 5'd4; rs1 = 5'd1; data1 = 64'h10;
      with_imm = 1'b1; imm = 64'h20;
      tick();
      chk("pre_stall_result", ex_result, 64'h30);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         data1 = 64'h1000 + 64'(i); pc = 64'h300 + 64'(i * 4);
         tick();
         chk("stall_result", ex_result, 64'h30);
         chk("stall_pc", ex_pc, 64'h200);
      end
      clear = 1'b1;
      tick();
      chk("clear_stall_valid", {63'd0, ex_valid}, 64'd0);
      chk("clear_stall_rd", {59'd0, ex_rd}, 64'd0);

      // async reset mid-stream
      idle();
      in_valid = 1'b1; set_op(OP_ADD); pc = 64'h1000; rd = 5'd3; rs1 = 5'd1; data1 = 64'h40;
      with_imm = 1'b1; imm = 64'h1;
      tick();
      chk("pre_rst_valid", {63'd0, ex_valid}, 64'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_valid", {63'd0, ex_valid}, 64'd0);
      chk("arst_pc", ex_pc, 64'h0);
      chk("arst_result", ex_result, 64'h0);
      chk("arst_next_pc", ex_next_pc, 64'h0);
      tick();
      chk("arst_hold_valid", {63'd0, ex_valid}, 64'd0);
      rst = 1'b0;
      idle();
      in_valid = 1'b1; set_op(OP_ADD); compressed = 1'b1; pc = 64'h400;
      tick();
      chk("c_next_pc", ex_next_pc, 64'h402);
      chk("c_pc", ex_pc, 64'h400);
      compressed = 1'b0;
      tick();
      chk("nc_next_pc", ex_next_pc, 64'h404);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
